// File: rtl/uart_reg_bank.sv
// Multi-channel 16550-style register bank: two-state access FSM, per-channel config and status.
// reg_ready one cycle after accept; side-effect pulses in the accept cycle; requests ignored in RESP.
module uart_reg_bank #(
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 16,
  localparam int LVL_W     = $clog2(FIFO_DEPTH + 1),
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CH_W+3:0]         reg_addr,
  input  logic                    reg_read,
  input  logic                    reg_write,
  input  logic [7:0]              reg_wdata,
  output logic [7:0]              reg_rdata,
  output logic                    reg_ready,
  output logic                    reg_err,
  output logic [NUM_CH-1:0]       thr_valid,
  output logic [7:0]              thr_data,
  input  logic [NUM_CH-1:0]       thr_ready,
  input  logic [NUM_CH-1:0]       tx_ready,
  input  logic [NUM_CH-1:0]       rhr_valid,
  output logic [NUM_CH-1:0]       rhr_ready,
  output logic [NUM_CH-1:0]       rd_rhr,
  input  logic [NUM_CH*8-1:0]     rhr_data,
  input  logic [NUM_CH*3-1:0]     rhr_err,
  input  logic [NUM_CH-1:0]       rx_overrun,
  input  logic [NUM_CH-1:0]       rx_fifo_err,
  input  logic [NUM_CH*LVL_W-1:0] tx_level,
  input  logic [NUM_CH*LVL_W-1:0] rx_level,
  input  logic [NUM_CH*4-1:0]     int_code,
  output logic [NUM_CH-1:0]       int_rx_line_status,
  output logic [NUM_CH*7-1:0]     cfg_lcr,
  output logic [NUM_CH-1:0]       cfg_fifo_enable,
  output logic [NUM_CH-1:0]       cfg_rx_reset,
  output logic [NUM_CH-1:0]       cfg_tx_reset,
  output logic [NUM_CH*LVL_W-1:0] cfg_rx_trig,
  output logic [NUM_CH*16-1:0]    cfg_div_const,
  output logic [NUM_CH*4-1:0]     cfg_int_en
);

  typedef enum logic {IDLE, RESP} state_t;
  state_t state;

  logic [CH_W-1:0] ch;
  logic [3:0]      off;
  logic            req, accept, err, ok;
  logic [7:0]      rd_val [NUM_CH];
  logic [7:0]      rd_sel;

  function automatic logic [7:0] sat8(input logic [LVL_W-1:0] v);
    logic [LVL_W+7:0] w;
    w = {8'b0, v};
    return (w > (LVL_W+8)'(255)) ? 8'hFF : w[7:0];
  endfunction

  assign ch       = reg_addr[CH_W+3:4];
  assign off      = reg_addr[3:0];
  assign req      = reg_read | reg_write;
  assign accept   = (state == IDLE) & req & ~rst;
  assign err      = (reg_read & reg_write) | (int'(ch) >= NUM_CH) | (off > 4'd10) |
                    (reg_write & (off == 4'd5 || off == 4'd6 || off == 4'd8 || off == 4'd9));
  assign ok       = accept & ~err;
  assign thr_data = reg_wdata;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [7:0]       lcr, dll, dlm, spr, rd_c, lsr;
    logic [3:0]       ier;
    logic [4:0]       mcr;
    logic             fe, ovr, cleared, dlab, sel, wr_en, rd_en, fcr_wr, lsr_rd, pop;
    logic [LVL_W-1:0] rxtrig, trig_nxt;
    logic [2:0]       err_masked;

    assign dlab       = lcr[7];
    assign sel        = ok & (ch == CH_W'(c));
    assign wr_en      = sel & reg_write;
    assign rd_en      = sel & reg_read;
    assign rhr_ready[c]    = rd_en & (off == 4'd0) & ~dlab;
    assign rd_rhr[c]       = rhr_ready[c];
    assign thr_valid[c]    = wr_en & (off == 4'd0) & ~dlab;
    assign fcr_wr          = wr_en & (off == 4'd2);
    assign cfg_rx_reset[c] = fcr_wr & reg_wdata[1];
    assign cfg_tx_reset[c] = fcr_wr & reg_wdata[2];
    assign lsr_rd     = rd_en & (off == 4'd5);
    assign pop        = rhr_valid[c] & rhr_ready[c];
    // Error bits stay hidden after an LSR read until the next character is popped.
    assign err_masked = cleared ? 3'b000 : rhr_err[3*c +: 3];
    assign lsr        = {rx_fifo_err[c] & fe, thr_ready[c] & tx_ready[c], thr_ready[c],
                         err_masked, ovr, rhr_valid[c]};

    assign int_rx_line_status[c]     = |{err_masked, ovr};
    assign cfg_lcr[7*c +: 7]         = lcr[6:0];
    assign cfg_fifo_enable[c]        = fe;
    assign cfg_rx_trig[LVL_W*c +: LVL_W] = rxtrig;
    assign cfg_div_const[16*c +: 16] = {dlm, dll};
    assign cfg_int_en[4*c +: 4]      = ier;
    assign rd_val[c]                 = rd_c;

    always_comb begin
      trig_nxt = rxtrig;
      if (fcr_wr) begin
        case (reg_wdata[7:6])
          2'b00:   trig_nxt = LVL_W'(1);
          2'b01:   trig_nxt = LVL_W'(FIFO_DEPTH / 4);
          2'b10:   trig_nxt = LVL_W'(FIFO_DEPTH / 2);
          default: trig_nxt = LVL_W'(FIFO_DEPTH - 2);
        endcase
      end else if (reg_wdata == 8'h00)
        trig_nxt = LVL_W'(1);
      else if (int'(reg_wdata) > FIFO_DEPTH)
        trig_nxt = LVL_W'(FIFO_DEPTH);
      else
        trig_nxt = LVL_W'(reg_wdata);
    end

    always_comb begin
      rd_c = 8'h00;
      case (off)
        4'd0:  rd_c = dlab ? dll : (rhr_valid[c] ? rhr_data[8*c +: 8] : 8'h00);
        4'd1:  rd_c = dlab ? dlm : {4'b0, ier};
        4'd2:  rd_c = {fe, fe, 2'b00, int_code[4*c +: 4]};
        4'd3:  rd_c = lcr;
        4'd4:  rd_c = {3'b0, mcr};
        4'd5:  rd_c = lsr;
        4'd7:  rd_c = spr;
        4'd8:  rd_c = sat8(tx_level[LVL_W*c +: LVL_W]);
        4'd9:  rd_c = sat8(rx_level[LVL_W*c +: LVL_W]);
        4'd10: rd_c = sat8(rxtrig);
        default: rd_c = 8'h00;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lcr <= 8'h03; dll <= 8'h01; dlm <= 8'h00; spr <= 8'h00;
        ier <= 4'h0;  mcr <= 5'h00; fe <= 1'b0;
        rxtrig <= LVL_W'(1); ovr <= 1'b0; cleared <= 1'b0;
      end else begin
        ovr <= rx_overrun[c] | (ovr & ~lsr_rd);
        if (pop)         cleared <= 1'b0;
        else if (lsr_rd) cleared <= 1'b1;
        if (wr_en) begin
          case (off)
            4'd0:  if (dlab) dll <= reg_wdata;
            4'd1:  if (dlab) dlm <= reg_wdata; else ier <= reg_wdata[3:0];
            4'd2:  begin fe <= reg_wdata[0]; rxtrig <= trig_nxt; end
            4'd3:  lcr <= reg_wdata;
            4'd4:  mcr <= reg_wdata[4:0];
            4'd7:  spr <= reg_wdata;
            4'd10: rxtrig <= trig_nxt;
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    rd_sel = 8'h00;
    for (int c = 0; c < NUM_CH; c++)
      if (ch == CH_W'(c)) rd_sel = rd_val[c];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      reg_ready <= 1'b0;
      reg_err   <= 1'b0;
      reg_rdata <= 8'h00;
    end else begin
      case (state)
        IDLE: if (req) begin
          state     <= RESP;
          reg_ready <= 1'b1;
          reg_err   <= err;
          reg_rdata <= (err | ~reg_read) ? 8'h00 : rd_sel;
        end
        RESP: begin
          state     <= IDLE;
          reg_ready <= 1'b0;
          reg_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_bank.sv
// Randomized bench for uart_reg_bank against a register-level behavioural model.
module tb_uart_reg_bank;
  localparam int NUM_CH = 3, FIFO_DEPTH = 16, LVL_W = 5, CH_W = 2, AW = CH_W + 4;

  logic clk = 1'b0, rst = 1'b1;
  logic [AW-1:0] reg_addr = '0;
  logic reg_read = 0, reg_write = 0;
  logic [7:0] reg_wdata = '0, reg_rdata, thr_data;
  logic reg_ready, reg_err;
  logic [NUM_CH-1:0] thr_valid, rhr_ready, rd_rhr, int_rx_line_status, cfg_fifo_enable;
  logic [NUM_CH-1:0] cfg_rx_reset, cfg_tx_reset;
  logic [NUM_CH-1:0] thr_ready = '0, tx_ready = '0, rhr_valid = '0, rx_overrun = '0, rx_fifo_err = '0;
  logic [NUM_CH*8-1:0] rhr_data = '0;
  logic [NUM_CH*3-1:0] rhr_err = '0;
  logic [NUM_CH*LVL_W-1:0] tx_level = '0, rx_level = '0, cfg_rx_trig;
  logic [NUM_CH*4-1:0] int_code = '0, cfg_int_en;
  logic [NUM_CH*7-1:0] cfg_lcr;
  logic [NUM_CH*16-1:0] cfg_div_const;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  uart_reg_bank #(.NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .reg_addr(reg_addr), .reg_read(reg_read), .reg_write(reg_write),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ready(reg_ready), .reg_err(reg_err),
    .thr_valid(thr_valid), .thr_data(thr_data), .thr_ready(thr_ready), .tx_ready(tx_ready),
    .rhr_valid(rhr_valid), .rhr_ready(rhr_ready), .rd_rhr(rd_rhr), .rhr_data(rhr_data),
    .rhr_err(rhr_err), .rx_overrun(rx_overrun), .rx_fifo_err(rx_fifo_err),
    .tx_level(tx_level), .rx_level(rx_level), .int_code(int_code),
    .int_rx_line_status(int_rx_line_status), .cfg_lcr(cfg_lcr),
    .cfg_fifo_enable(cfg_fifo_enable), .cfg_rx_reset(cfg_rx_reset), .cfg_tx_reset(cfg_tx_reset),
    .cfg_rx_trig(cfg_rx_trig), .cfg_div_const(cfg_div_const), .cfg_int_en(cfg_int_en)
  );

  // Behavioural register image per channel
  logic [7:0] m_lcr [NUM_CH], m_dll [NUM_CH], m_dlm [NUM_CH], m_spr [NUM_CH];
  logic [3:0] m_ier [NUM_CH];
  logic [4:0] m_mcr [NUM_CH];
  bit         m_fe [NUM_CH], m_ovr [NUM_CH], m_clr [NUM_CH];
  int         m_trig [NUM_CH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_lcr[k] = 8'h03; m_dll[k] = 8'h01; m_dlm[k] = 8'h00; m_spr[k] = 8'h00;
      m_ier[k] = 4'h0; m_mcr[k] = 5'h00; m_fe[k] = 0; m_ovr[k] = 0; m_clr[k] = 0; m_trig[k] = 1;
    end
  endtask

  function automatic logic [2:0] m_errv(int k);
    return m_clr[k] ? 3'b000 : rhr_err[3*k +: 3];
  endfunction

  task automatic check_cfg();
    for (int k = 0; k < NUM_CH; k++) begin
      check($sformatf("cfg_lcr ch%0d", k), cfg_lcr[7*k +: 7], m_lcr[k][6:0]);
      check($sformatf("div ch%0d", k), cfg_div_const[16*k +: 16], {m_dlm[k], m_dll[k]});
      check($sformatf("fe ch%0d", k), cfg_fifo_enable[k], m_fe[k]);
      check($sformatf("trig ch%0d", k), cfg_rx_trig[LVL_W*k +: LVL_W], m_trig[k]);
      check($sformatf("int_en ch%0d", k), cfg_int_en[4*k +: 4], m_ier[k]);
      check($sformatf("line_int ch%0d", k), int_rx_line_status[k], (|m_errv(k)) | m_ovr[k]);
    end
  endtask

  task automatic quiet_inputs();
    thr_ready = '0; tx_ready = '0; rhr_valid = '0; rx_overrun = '0; rx_fifo_err = '0;
    rhr_data = '0; rhr_err = '0; tx_level = '0; rx_level = '0; int_code = '0;
  endtask

  task automatic random_inputs();
    thr_ready = NUM_CH'($urandom); tx_ready = NUM_CH'($urandom); rhr_valid = NUM_CH'($urandom);
    rx_fifo_err = NUM_CH'($urandom); rhr_data = (NUM_CH*8)'($urandom);
    rhr_err = (NUM_CH*3)'($urandom); int_code = (NUM_CH*4)'($urandom);
    rx_overrun = ($urandom_range(0, 5) == 0) ? NUM_CH'($urandom) : '0;
    for (int k = 0; k < NUM_CH; k++) begin
      tx_level[LVL_W*k +: LVL_W] = LVL_W'($urandom_range(0, FIFO_DEPTH));
      rx_level[LVL_W*k +: LVL_W] = LVL_W'($urandom_range(0, FIFO_DEPTH));
    end
  endtask

  task automatic ovr_pulse(input logic [NUM_CH-1:0] m);
    rx_overrun = m;
    @(posedge clk); #1;
    for (int k = 0; k < NUM_CH; k++) if (m[k]) m_ovr[k] = 1;
    rx_overrun = '0;
  endtask

  // One complete access: predict, drive, check pulses, response and config image.
  task automatic acc(input bit rd, input bit wr, input int c, input int off,
                     input logic [7:0] wd, output logic [7:0] got, output logic got_err);
    logic [7:0] e_rd;
    bit e_err, ok, dl;
    logic [NUM_CH-1:0] e_thr, e_pop, e_rxr, e_txr;
    e_err = (rd && wr) || c >= NUM_CH || off > 10 ||
            (wr && (off == 5 || off == 6 || off == 8 || off == 9));
    ok = !e_err;
    dl = ok && m_lcr[c][7];
    e_rd = 8'h00; e_thr = '0; e_pop = '0; e_rxr = '0; e_txr = '0;
    if (ok && rd) begin
      case (off)
        0:  e_rd = dl ? m_dll[c] : (rhr_valid[c] ? rhr_data[8*c +: 8] : 8'h00);
        1:  e_rd = dl ? m_dlm[c] : {4'h0, m_ier[c]};
        2:  e_rd = {m_fe[c], m_fe[c], 2'b00, int_code[4*c +: 4]};
        3:  e_rd = m_lcr[c];
        4:  e_rd = {3'b000, m_mcr[c]};
        5:  e_rd = {rx_fifo_err[c] & m_fe[c], thr_ready[c] & tx_ready[c], thr_ready[c],
                    m_errv(c), m_ovr[c], rhr_valid[c]};
        7:  e_rd = m_spr[c];
        8:  e_rd = {3'b000, tx_level[LVL_W*c +: LVL_W]};
        9:  e_rd = {3'b000, rx_level[LVL_W*c +: LVL_W]};
        10: e_rd = 8'(m_trig[c]);
        default: e_rd = 8'h00;
      endcase
      if (off == 0 && !dl) e_pop[c] = 1'b1;
    end
    if (ok && wr && off == 0 && !dl) e_thr[c] = 1'b1;
    if (ok && wr && off == 2) begin e_rxr[c] = wd[1]; e_txr[c] = wd[2]; end

    reg_addr = AW'(c * 16 + off); reg_read = rd; reg_write = wr; reg_wdata = wd;
    #1;
    check("thr_valid", thr_valid, e_thr);
    if (e_thr != 0) check("thr_data", thr_data, wd);
    check("rhr_ready", rhr_ready, e_pop);
    check("rd_rhr", rd_rhr, e_pop);
    check("rx_reset", cfg_rx_reset, e_rxr);
    check("tx_reset", cfg_tx_reset, e_txr);
    check("ready_early", reg_ready, 1'b0);
    @(posedge clk); #1;

    if (ok && wr) begin
      case (off)
        0:  if (dl) m_dll[c] = wd;
        1:  if (dl) m_dlm[c] = wd; else m_ier[c] = wd[3:0];
        2:  begin
              m_fe[c] = wd[0];
              m_trig[c] = (wd[7:6] == 0) ? 1 : (wd[7:6] == 1) ? FIFO_DEPTH / 4 :
                          (wd[7:6] == 2) ? FIFO_DEPTH / 2 : FIFO_DEPTH - 2;
            end
        3:  m_lcr[c] = wd;
        4:  m_mcr[c] = wd[4:0];
        7:  m_spr[c] = wd;
        10: m_trig[c] = (wd == 0) ? 1 : (int'(wd) > FIFO_DEPTH) ? FIFO_DEPTH : int'(wd);
        default: ;
      endcase
    end
    if (ok && rd && off == 5) begin m_ovr[c] = 0; m_clr[c] = 1; end
    if (ok && e_pop[c] && rhr_valid[c]) m_clr[c] = 0;
    for (int k = 0; k < NUM_CH; k++) if (rx_overrun[k]) m_ovr[k] = 1;

    check("ready", reg_ready, 1'b1);
    check($sformatf("err ch%0d off%0d", c, off), reg_err, e_err);
    check($sformatf("rdata ch%0d off%0d", c, off), reg_rdata, e_rd);
    got = reg_rdata; got_err = reg_err;
    check("pulses_resp", {thr_valid, rhr_ready, cfg_rx_reset, cfg_tx_reset}, '0);
    reg_read = 0; reg_write = 0; rx_overrun = '0;
    @(posedge clk); #1;
    check("ready_drop", reg_ready, 1'b0);
    check_cfg();
  endtask

  initial begin
    logic [7:0] got;
    logic ge;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst ready", reg_ready, 1'b0);
    check("rst err", reg_err, 1'b0);
    check("rst rdata", reg_rdata, 8'h00);
    check_cfg();
    rst = 0;
    @(posedge clk); #1;

    acc(1, 0, 1, 3, 8'h00, got, ge);
    check("ch1 lcr reset", got, 8'h03);

    acc(0, 1, 0, 3, 8'h80, got, ge);
    acc(0, 1, 0, 0, 8'h1A, got, ge);
    acc(0, 1, 0, 1, 8'h00, got, ge);
    acc(0, 1, 0, 3, 8'h03, got, ge);
    check("ch0 divisor", cfg_div_const[15:0], 16'h001A);
    check("ch1 divisor", cfg_div_const[31:16], 16'h0001);

    acc(0, 1, 0, 2, 8'hC7, got, ge);
    check("fcr fe", cfg_fifo_enable[0], 1'b1);
    acc(1, 0, 0, 10, 8'h00, got, ge);
    check("trig fcr", got, 8'd14);
    acc(0, 1, 0, 10, 8'h40, got, ge);
    acc(1, 0, 0, 10, 8'h00, got, ge);
    check("trig clamp hi", got, 8'd16);
    acc(0, 1, 0, 10, 8'h00, got, ge);
    acc(1, 0, 0, 10, 8'h00, got, ge);
    check("trig clamp lo", got, 8'd1);

    quiet_inputs();
    ovr_pulse(3'b010);
    acc(1, 0, 1, 5, 8'h00, got, ge);
    check("lsr ovr set", got, 8'h02);
    acc(1, 0, 1, 5, 8'h00, got, ge);
    check("lsr ovr clr", got, 8'h00);
    rx_overrun = 3'b010;
    acc(1, 0, 1, 5, 8'h00, got, ge);
    acc(1, 0, 1, 5, 8'h00, got, ge);
    check("lsr ovr tie", got[1], 1'b1);

    quiet_inputs();
    rhr_valid[2] = 1'b1; rhr_err[8:6] = 3'b010;
    #1 check("line_int fe", int_rx_line_status[2], 1'b1);
    acc(1, 0, 2, 5, 8'h00, got, ge);
    check("lsr framing", got, 8'h09);
    acc(1, 0, 2, 5, 8'h00, got, ge);
    check("lsr masked", got[4:2], 3'b000);
    check("line_int masked", int_rx_line_status[2], 1'b0);
    acc(1, 0, 2, 0, 8'h00, got, ge);
    acc(1, 0, 2, 5, 8'h00, got, ge);
    check("lsr after pop", got[4:2], 3'b010);

    acc(1, 0, 3, 3, 8'h00, got, ge);
    check("bad ch err", ge, 1'b1);
    check("bad ch rdata", got, 8'h00);
    acc(1, 0, 0, 12, 8'h00, got, ge);
    check("off12 err", ge, 1'b1);
    acc(0, 1, 0, 8, 8'h55, got, ge);
    check("wr txlvl err", ge, 1'b1);
    acc(1, 1, 0, 0, 8'h66, got, ge);
    check("rd+wr err", ge, 1'b1);

    for (int i = 0; i < 400; i++) begin
      int mode;
      random_inputs();
      mode = $urandom_range(0, 7);
      acc(mode == 0 || mode >= 4, mode <= 3, $urandom_range(0, 3), $urandom_range(0, 15),
          8'($urandom), got, ge);
      if ($urandom_range(0, 9) == 0) ovr_pulse(NUM_CH'($urandom));
    end

    // Reset arriving while a write is pending
    quiet_inputs();
    reg_addr = AW'(7); reg_write = 1; reg_wdata = 8'h5A;
    #2 rst = 1;
    #1 check("rst thr gate", thr_valid, '0);
    @(posedge clk); #1;
    reg_addr = AW'(0);
    #1 check("rst thr gate2", thr_valid, '0);
    check("rst no ready", reg_ready, 1'b0);
    reg_write = 0;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort ready", reg_ready, 1'b0);
    end
    acc(1, 0, 0, 7, 8'h00, got, ge);
    check("abort spr", got, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
